// File: rtl/capture_controller_pkg.sv
// Shared types and constants for the camera capture controller.
package capture_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } cap_state_e;

    localparam int   FRAME_PIX_DEF = 19200;
    localparam logic HIGH          = 1'b1;
    localparam logic LOW           = 1'b0;

endpackage

// File: rtl/capture_controller_vsync_edge.sv
// Single-flop VSYNC edge detector; pulses are valid in the cycle the new level is first seen.
module capture_controller_vsync_edge
    import capture_controller_pkg::*;
(
    input  logic PCLK_i,
    input  logic Reset_i,
    input  logic VSYNC_i,
    output logic Rise_o,
    output logic Fall_o
);

    logic vsync_q;

    always_ff @(posedge PCLK_i) begin
        if (Reset_i) begin
            vsync_q <= LOW;
        end else begin
            vsync_q <= VSYNC_i;
        end
    end

    assign Rise_o = VSYNC_i & ~vsync_q;
    assign Fall_o = ~VSYNC_i & vsync_q;

endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: arms on config, writes one frame into the shared buffer,
// then lends the buffer port to a readout client until it signals done.
//   state      | meaning
//   ST_IDLE    | pixel path off, buffer locked
//   ST_ARM     | pixel path on, waiting for VSYNC rise to start a frame
//   ST_CAPTURE | writer owns the buffer, one word per pixel strobe
//   ST_READOUT | frame closed, reader owns the buffer port
module capture_controller
    import capture_controller_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int FRAME_PIX = FRAME_PIX_DEF,
    parameter int CNT_W     = 8
) (
    input  logic              PCLK_i,
    input  logic              Reset_i,
    input  logic              Config_Done_i,
    input  logic              Start_i,
    input  logic              Stop_i,
    input  logic              Continuous_i,
    input  logic              VSYNC_i,
    input  logic [DATA_W-1:0] Pixel_i,
    input  logic              Pixel_Available_i,
    output logic              Enable_o,
    output logic              Buff_Lock_o,
    output logic              Mem_We_o,
    output logic [ADDR_W-1:0] Mem_Addr_o,
    output logic [DATA_W-1:0] Mem_Data_o,
    input  logic              Rd_Req_i,
    input  logic [ADDR_W-1:0] Rd_Addr_i,
    output logic              Rd_Ack_o,
    input  logic              Rd_Done_i,
    output logic              Frame_Ready_o,
    output logic              Short_Frame_o,
    output logic              Overflow_o,
    output logic [CNT_W-1:0]  Frame_Count_o
);

    // One extra bit so a buffer of exactly 2**ADDR_W words still has a distinct "full" value.
    localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(FRAME_PIX);

    cap_state_e        state_q;
    logic [ADDR_W:0]   wr_addr_q;
    logic [ADDR_W:0]   wr_addr_d;
    logic              close_q;
    logic              en_q;
    logic              lock_q;
    logic              ready_q;
    logic              we_q;
    logic              ack_q;
    logic              short_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count_q;
    logic              vsync_rise;
    logic              vsync_fall_unused;
    logic              abort;

    capture_controller_vsync_edge u_vsync_edge (
        .PCLK_i  (PCLK_i),
        .Reset_i (Reset_i),
        .VSYNC_i (VSYNC_i),
        .Rise_o  (vsync_rise),
        .Fall_o  (vsync_fall_unused)
    );

    assign abort     = Stop_i | ~Config_Done_i;
    assign wr_addr_d = wr_addr_q + (ADDR_W+1)'(1);

    always_ff @(posedge PCLK_i) begin
        if (Reset_i) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            close_q   <= LOW;
            en_q      <= LOW;
            lock_q    <= HIGH;
            ready_q   <= LOW;
            we_q      <= LOW;
            ack_q     <= LOW;
            short_q   <= LOW;
            ovf_q     <= LOW;
            addr_q    <= '0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            we_q  <= LOW;
            ack_q <= LOW;
            if (abort) begin
                state_q <= ST_IDLE;
                en_q    <= LOW;
                lock_q  <= HIGH;
                ready_q <= LOW;
                close_q <= LOW;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (Start_i) begin
                            state_q <= ST_ARM;
                            en_q    <= HIGH;
                        end
                    end
                    ST_ARM: begin
                        if (vsync_rise) begin
                            state_q   <= ST_CAPTURE;
                            lock_q    <= LOW;
                            wr_addr_q <= '0;
                            addr_q    <= '0;
                            short_q   <= LOW;
                            ovf_q     <= LOW;
                        end
                    end
                    ST_CAPTURE: begin
                        // Leave one cycle after the last write so Mem_We_o drops while still in CAPTURE.
                        if (close_q || wr_addr_q == FRAME_END) begin
                            state_q <= ST_READOUT;
                            lock_q  <= HIGH;
                            ready_q <= HIGH;
                            close_q <= LOW;
                            count_q <= count_q + CNT_W'(1);
                            if (Pixel_Available_i && wr_addr_q == FRAME_END) begin
                                ovf_q <= HIGH;
                            end
                        end else begin
                            if (Pixel_Available_i) begin
                                we_q      <= HIGH;
                                addr_q    <= wr_addr_q[ADDR_W-1:0];
                                data_q    <= Pixel_i;
                                wr_addr_q <= wr_addr_d;
                            end
                            if (vsync_rise) begin
                                close_q <= HIGH;
                                short_q <= (Pixel_Available_i ? wr_addr_d : wr_addr_q) != FRAME_END;
                            end
                        end
                    end
                    ST_READOUT: begin
                        ack_q <= Rd_Req_i;
                        if (Rd_Done_i) begin
                            ready_q <= LOW;
                            en_q    <= Continuous_i;
                            state_q <= Continuous_i ? ST_ARM : ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        Mem_Addr_o = '0;
        if (state_q == ST_READOUT && Rd_Req_i) begin
            Mem_Addr_o = Rd_Addr_i;
        end else if (state_q == ST_CAPTURE) begin
            Mem_Addr_o = addr_q;
        end
    end

    assign Enable_o      = en_q;
    assign Buff_Lock_o   = lock_q;
    assign Mem_We_o      = we_q;
    assign Mem_Data_o    = data_q;
    assign Rd_Ack_o      = ack_q;
    assign Frame_Ready_o = ready_q;
    assign Short_Frame_o = short_q;
    assign Overflow_o    = ovf_q;
    assign Frame_Count_o = count_q;

endmodule
